// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding and frame constants.
package uart_pkg;

  localparam int OVS    = 16;
  localparam int MID    = 8;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_flag.sv
// Set/clear status flag; set wins over clear, synchronous reset to 0.
module uart_rx_flag (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic clr,
  output logic q
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (rst)      r_q <= 1'b0;
    else if (set) r_q <= 1'b1;
    else if (clr) r_q <= 1'b0;
  end

  assign q = r_q;

endmodule

// File: rtl/uart_rx_engine.sv
// UART receiver: 16x oversampled deserializer with parity, framing and overrun
// status held for the host until read.
module uart_rx_engine
  import uart_pkg::*;
#(
  parameter int OVS_DIV = 54
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic              eight,
  input  logic              pen,
  input  logic              ohel,
  input  logic              read,
  output logic [DATA_W-1:0] rx_data,
  output logic              rxrdy,
  output logic              perr,
  output logic              ferr,
  output logic              ovf
);

  localparam int TW = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;

  rx_state_e         r_state, w_state_next;
  logic              r_rx_meta, r_rx_s;
  logic [TW-1:0]     r_tick_cnt;
  logic [3:0]        r_samp_cnt;
  logic [3:0]        r_bit_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_eight, r_pen, r_ohel;
  logic              r_perr_next, r_ferr_next;
  logic              r_done;
  logic              r_armed;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_perr, r_ferr, r_ovf;

  logic              w_tick, w_sample, w_go_data;
  logic              w_shift, w_par_sample, w_stop_sample;
  logic [3:0]        w_last_bit;
  logic [DATA_W-1:0] w_data;
  logic              w_rxrdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  assign w_tick = (r_tick_cnt == TW'(OVS_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || w_tick) r_tick_cnt <= '0;
    else               r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  assign w_last_bit = r_eight ? 4'd7 : 4'd6;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_tick && !r_rx_s && r_armed) w_state_next = START;
      START:   if (w_tick && r_samp_cnt == 4'(MID - 1))
                 w_state_next = r_rx_s ? IDLE : DATA;
      DATA:    if (w_sample && r_bit_cnt == w_last_bit)
                 w_state_next = r_pen ? PARITY : STOP;
      PARITY:  if (w_sample) w_state_next = STOP;
      STOP:    if (w_sample) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_sample      = 1'b0;
    w_go_data     = 1'b0;
    w_shift       = 1'b0;
    w_par_sample  = 1'b0;
    w_stop_sample = 1'b0;
    if (r_state == START && w_tick && r_samp_cnt == 4'(MID - 1) && !r_rx_s)
      w_go_data = 1'b1;
    if ((r_state == DATA || r_state == PARITY || r_state == STOP) &&
        w_tick && r_samp_cnt == 4'(OVS - 1))
      w_sample = 1'b1;
    w_shift       = w_sample && (r_state == DATA);
    w_par_sample  = w_sample && (r_state == PARITY);
    w_stop_sample = w_sample && (r_state == STOP);
  end

  // 7-bit frames land in shift[7:1]; realign so bit 7 reads as 0.
  assign w_data = r_eight ? r_shift : {1'b0, r_shift[DATA_W-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_samp_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_eight     <= 1'b0;
      r_pen       <= 1'b0;
      r_ohel      <= 1'b0;
      r_perr_next <= 1'b0;
      r_ferr_next <= 1'b0;
      r_done      <= 1'b0;
      r_armed     <= 1'b0;
    end else begin
      r_done <= w_stop_sample;
      if (r_state == IDLE || w_go_data) r_samp_cnt <= '0;
      else if (w_tick)                   r_samp_cnt <= r_samp_cnt + 1'b1;
      if (w_go_data) begin
        r_bit_cnt <= '0;
        r_eight   <= eight;
        r_pen     <= pen;
        r_ohel    <= ohel;
      end
      if (w_shift) begin
        r_shift   <= {r_rx_s, r_shift[DATA_W-1:1]};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      if (w_par_sample)  r_perr_next <= (^w_data) ^ r_rx_s ^ r_ohel;
      if (w_stop_sample) r_ferr_next <= ~r_rx_s;
      // A low stop bit (break) must see the line go high before a new start.
      if (w_stop_sample && !r_rx_s) r_armed <= 1'b0;
      else if (r_rx_s)              r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_data <= '0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (r_done) begin
      r_rx_data <= w_data;
      r_perr    <= r_pen & r_perr_next;
      r_ferr    <= r_ferr_next;
      r_ovf     <= w_rxrdy & ~read;
    end else if (read) begin
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
      r_ovf  <= 1'b0;
    end
  end

  uart_rx_flag u_rxrdy (
    .clk (clk),
    .rst (rst),
    .set (r_done),
    .clr (read),
    .q   (w_rxrdy)
  );

  assign rx_data = r_rx_data;
  assign rxrdy   = w_rxrdy;
  assign perr    = r_perr;
  assign ferr    = r_ferr;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine with OVS_DIV=4 (64 clk per bit).
module tb_uart_rx_engine;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       eight = 1'b1;
  logic       pen = 1'b0;
  logic       ohel = 1'b0;
  logic       read = 1'b0;
  logic [7:0] rx_data;
  logic       rxrdy, perr, ferr, ovf;

  int n_assert = 0;
  int n_fail   = 0;

  uart_rx_engine #(.OVS_DIV(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx),
    .eight   (eight),
    .pen     (pen),
    .ohel    (ohel),
    .read    (read),
    .rx_data (rx_data),
    .rxrdy   (rxrdy),
    .perr    (perr),
    .ferr    (ferr),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] d, input logic rdy,
                           input logic pe, input logic fe, input logic ov);
    check({tag, ".rx_data"}, rx_data, d);
    check({tag, ".rxrdy"}, {7'd0, rxrdy}, {7'd0, rdy});
    check({tag, ".perr"}, {7'd0, perr}, {7'd0, pe});
    check({tag, ".ferr"}, {7'd0, ferr}, {7'd0, fe});
    check({tag, ".ovf"}, {7'd0, ovf}, {7'd0, ov});
    $display("%s: rx_data=%h rxrdy=%b perr=%b ferr=%b ovf=%b", tag, rx_data, rxrdy, perr, ferr, ovf);
  endtask

  task automatic hold_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input int nbits, input logic par_en,
                            input logic par_bit, input logic stop_bit, input logic rd_on_done);
    logic saw;
    saw = 1'b0;
    hold_bit(1'b0);
    for (int i = 0; i < nbits; i++) hold_bit(data[i]);
    if (par_en) hold_bit(par_bit);
    rx = stop_bit;
    for (int i = 0; i < BIT_CLKS; i++) begin
      @(negedge clk);
      if (rd_on_done && !saw && dut.r_done) begin
        read = 1'b1;
        saw  = 1'b1;
      end else begin
        read = 1'b0;
      end
    end
    read = 1'b0;
    rx = 1'b1;
    repeat (32) @(negedge clk);
    if (rd_on_done) check("read_in_done_cycle_found", {7'd0, saw}, 8'd1);
  endtask

  task automatic pulse_read();
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (40) @(negedge clk);

    // 1: 8N1 A5, then read
    eight = 1'b1; pen = 1'b0; ohel = 1'b0;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    check_all("t1_rx_A5", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_read();
    check_all("t1_after_read", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);

    // 2: 8E1, bad then good parity
    eight = 1'b1; pen = 1'b1; ohel = 1'b0;
    send_frame(8'h03, 8, 1'b1, 1'b1, 1'b1, 1'b0);
    check_all("t2_even_bad_par", 8'h03, 1'b1, 1'b1, 1'b0, 1'b0);
    pulse_read();
    check_all("t2_read_clears", 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h03, 8, 1'b1, 1'b0, 1'b1, 1'b0);
    check_all("t2_even_good_par", 8'h03, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_read();

    // 3: 7O1 0x41, then framing error
    eight = 1'b0; pen = 1'b1; ohel = 1'b1;
    send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1, 1'b0);
    check_all("t3_7bit_odd", 8'h41, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_read();
    send_frame(8'h41, 7, 1'b1, 1'b1, 1'b0, 1'b0);
    check_all("t3_stop_low", 8'h41, 1'b1, 1'b0, 1'b1, 1'b0);
    pulse_read();
    check_all("t3_read_clears", 8'h41, 1'b0, 1'b0, 1'b0, 1'b0);

    // 4: short glitch must not start a frame
    eight = 1'b1; pen = 1'b0; ohel = 1'b0;
    repeat (64) @(negedge clk);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (800) @(negedge clk);
    check_all("t4_glitch", 8'h41, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t4_fsm_idle", {5'd0, dut.r_state}, 8'd0);

    // 5: overrun, then read coinciding with done
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    check_all("t5_first", 8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    check_all("t5_overrun", 8'h22, 1'b1, 1'b0, 1'b0, 1'b1);
    pulse_read();
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 1'b1);
    check_all("t5_read_on_done", 8'h22, 1'b1, 1'b0, 1'b0, 1'b0);

    // 6: reset during the 4th data bit of 0x5A, then a clean 0x5A
    hold_bit(1'b0);
    hold_bit(1'b0);
    hold_bit(1'b1);
    hold_bit(1'b0);
    rx = 1'b1;
    repeat (32) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all("t6_mid_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (800) @(negedge clk);
    check_all("t6_quiet_after_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    check_all("t6_rx_5A", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
